asic_function_arbiter: RTL

Round-robin arbiter and sequencer that shares the single ASIC nonlinear-function interface among NUM_REQ requesters, such as reservoir node engines or a software path. It sits between the requesters and the ASIC pins: it drives asic_data_out and a start pulse, waits for a rising edge on done, captures the ASIC result and returns it to the granted requester. A watchdog timeout guards against a hung ASIC.

---
 rtl/asic_function_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/asic_function_arbiter.sv
// asic_function_arbiter
// Round-robin arbiter and sequencer sharing one ASIC nonlinear-function port
// among NUM_REQ requesters. An accepted operand is driven to the ASIC, held
// for SETTLE_CYCLES, then launched with a one-cycle start pulse. Completion is
// a rising edge of asic_done; a watchdog aborts hung operations. The result
// (or a zero with rsp_timeout set) is returned to the granted requester.
module asic_function_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          Local_Reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_timeout,
  output logic [DATA_WIDTH-1:0]         asic_data_out,
  output logic                          asic_start,
  input  logic                          asic_done,
  input  logic [DATA_WIDTH-1:0]         asic_data_in,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [15:0]                   timeout_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDW-1:0] LAST_INIT   = IDW'(NUM_REQ - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [SCW-1:0] SC_ONE      = SCW'(1);
  localparam logic [WDW-1:0] WD_LAST     = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [WDW-1:0] WD_ONE      = WDW'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESPOND = 3'd4
  } state_t;

  // With no settle time the operand goes straight to the start pulse.
  localparam state_t ACCEPT_NEXT = (SETTLE_CYCLES == 0) ? ST_START : ST_SETTLE;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin search starting just after the last grant; returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [IDW-1:0]     last);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] pick;
    int             pos;
    found = 1'b0;
    pick  = {IDW{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last) + k) % NUM_REQ;
      idx = IDW'(pos);
      if (!found && valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

  state_t                  state_r;
  state_t                  state_next_s;
  logic [IDW-1:0]          last_grant_r;
  logic [IDW-1:0]          grant_id_r;
  logic [SCW-1:0]          settle_cnt_r;
  logic [WDW-1:0]          wd_r;
  logic                    done_q_r;
  logic                    asic_start_r;
  logic [DATA_WIDTH-1:0]   asic_data_out_r;
  logic [DATA_WIDTH-1:0]   rsp_data_r;
  logic                    rsp_timeout_r;
  logic [15:0]             timeout_count_r;

  logic                    rr_found_s;
  logic [IDW-1:0]          rr_idx_s;
  logic                    edge_s;
  logic                    wd_expire_s;
  logic                    rsp_hs_s;
  logic [NUM_REQ-1:0]      req_ready_s;
  logic [NUM_REQ-1:0]      rsp_valid_s;
  logic                    busy_s;

  assign {rr_found_s, rr_idx_s} = rr_pick(req_valid, last_grant_r);

  // Only a fresh rising edge of done counts; a level left high is ignored.
  assign edge_s      = asic_done & ~done_q_r;
  assign wd_expire_s = (wd_r == WD_LAST);
  assign rsp_hs_s    = rsp_ready[grant_id_r];

  // Next-state selection for the operation sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rr_found_s) state_next_s = ACCEPT_NEXT;
        else            state_next_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) state_next_s = ST_START;
        else                             state_next_s = ST_SETTLE;
      end
      ST_START: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (edge_s || wd_expire_s) state_next_s = ST_RESPOND;
        else                       state_next_s = ST_WAIT;
      end
      ST_RESPOND: begin
        if (rsp_hs_s) state_next_s = ST_IDLE;
        else          state_next_s = ST_RESPOND;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Handshake and status decode; req_ready is the only combinational accept path.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    rsp_valid_s = {NUM_REQ{1'b0}};
    busy_s      = (state_r != ST_IDLE);
    if ((state_r == ST_IDLE) && rr_found_s && !Local_Reset) begin
      req_ready_s = onehot(rr_idx_s);
    end else begin
      req_ready_s = {NUM_REQ{1'b0}};
    end
    if (state_r == ST_RESPOND) begin
      rsp_valid_s = onehot(grant_id_r);
    end else begin
      rsp_valid_s = {NUM_REQ{1'b0}};
    end
  end

  // Sequencer state register.
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: operand launch, settle/watchdog counting, result capture, bookkeeping.
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      last_grant_r    <= LAST_INIT;
      grant_id_r      <= {IDW{1'b0}};
      settle_cnt_r    <= {SCW{1'b0}};
      wd_r            <= {WDW{1'b0}};
      done_q_r        <= 1'b0;
      asic_start_r    <= 1'b0;
      asic_data_out_r <= {DATA_WIDTH{1'b0}};
      rsp_data_r      <= {DATA_WIDTH{1'b0}};
      rsp_timeout_r   <= 1'b0;
      timeout_count_r <= 16'h0000;
    end else begin
      // done_q tracks the level in every state so a stale high never looks like an edge.
      done_q_r     <= asic_done;
      asic_start_r <= (state_next_s == ST_START);
      case (state_r)
        ST_IDLE: begin
          if (rr_found_s) begin
            asic_data_out_r <= req_data[rr_idx_s*DATA_WIDTH +: DATA_WIDTH];
            grant_id_r      <= rr_idx_s;
            settle_cnt_r    <= {SCW{1'b0}};
          end
        end
        ST_SETTLE: begin
          settle_cnt_r <= settle_cnt_r + SC_ONE;
        end
        ST_START: begin
          wd_r <= {WDW{1'b0}};
        end
        ST_WAIT: begin
          // A completion edge on the expiry cycle takes priority over the abort.
          if (edge_s) begin
            rsp_data_r    <= asic_data_in;
            rsp_timeout_r <= 1'b0;
          end else if (wd_expire_s) begin
            rsp_data_r    <= {DATA_WIDTH{1'b0}};
            rsp_timeout_r <= 1'b1;
            if (timeout_count_r != 16'hFFFF) begin
              timeout_count_r <= timeout_count_r + 16'd1;
            end
          end else begin
            wd_r <= wd_r + WD_ONE;
          end
        end
        ST_RESPOND: begin
          if (rsp_hs_s) begin
            last_grant_r <= grant_id_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready     = req_ready_s;
  assign rsp_valid     = rsp_valid_s;
  assign busy          = busy_s;
  assign rsp_data      = rsp_data_r;
  assign rsp_timeout   = rsp_timeout_r;
  assign asic_data_out = asic_data_out_r;
  assign asic_start    = asic_start_r;
  assign grant_id      = grant_id_r;
  assign timeout_count = timeout_count_r;

endmodule
